timer_clock_select: RTL

Clock-source and prescaler stage that sits directly upstream of the 8-bit timer counter and generates its CounterClock input.
- Selects between a stopped clock, five prescaled taps of the system clock, and a synchronised external pin.
- Switches sources glitch-free, so the counter never sees a spurious edge.
- Runs entirely in the SysClock domain.

---
 rtl/timer_pkg.sv | 44 ++++
 rtl/timer_sync.sv | 31 +++
 rtl/timer_clock_select.sv | 103 ++++++++++
 3 files changed

// File: rtl/timer_pkg.sv
// Shared timer definitions: clock-select encodings, divisor table, clock-select
// FSM state encoding and the counter edge-mode constants.
package timer_pkg;

  typedef enum logic [2:0] {
    SEL_STOP    = 3'b000,
    SEL_DIV2    = 3'b001,
    SEL_DIV8    = 3'b010,
    SEL_DIV64   = 3'b011,
    SEL_DIV256  = 3'b100,
    SEL_DIV1024 = 3'b101,
    SEL_EXT     = 3'b110,
    SEL_RSVD    = 3'b111
  } clk_sel_e;

  typedef enum logic [1:0] {
    EDGE_PROHIBITED = 2'b00,
    EDGE_RISING     = 2'b01,
    EDGE_FALLING    = 2'b10,
    EDGE_BOTH       = 2'b11
  } edge_mode_e;

  localparam logic [1:0] ST_STOP   = 2'd0;
  localparam logic [1:0] ST_SWITCH = 2'd1;
  localparam logic [1:0] ST_RUN    = 2'd2;

  // Terminal prescaler count (N-1) for a divided source; 0 for anything else.
  function automatic int unsigned term_count(input logic [2:0] sel);
    case (sel)
      SEL_DIV2:    term_count = 1;
      SEL_DIV8:    term_count = 7;
      SEL_DIV64:   term_count = 63;
      SEL_DIV256:  term_count = 255;
      SEL_DIV1024: term_count = 1023;
      default:     term_count = 0;
    endcase
  endfunction

  // Stop and reserved encodings keep the counter clock parked.
  function automatic logic sel_is_source(input logic [2:0] sel);
    sel_is_source = (sel != SEL_STOP) && (sel != SEL_RSVD);
  endfunction

endpackage

// File: rtl/timer_sync.sv
// Single-bit multi-flop synchroniser for an asynchronous input pin.
// Ports: clk, rst_n (async active-low), d (async input), q (synchronised).
module timer_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  // Shift the pin through the flop chain.
  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = d;
    for (int unsigned i = 1; i < STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= sync_d;
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/timer_clock_select.sv
// Timer clock-source select and prescaler; produces the timer CounterClock.
// Ports: SysClock/SysResetN (async active-low), ClockSelect (source select),
// ExternalClock (async pin), PrescalerClear (sync clear), CounterClock
// (registered counter clock), Running (non-stop source active),
// PrescalerValue (prescaler readback).
module timer_clock_select
  import timer_pkg::*;
#(
  parameter int unsigned PRESCALER_WIDTH = 10,
  parameter int unsigned SYNC_STAGES     = 2
) (
  input  logic                       SysClock,
  input  logic                       SysResetN,
  input  logic [2:0]                 ClockSelect,
  input  logic                       ExternalClock,
  input  logic                       PrescalerClear,
  output logic                       CounterClock,
  output logic                       Running,
  output logic [PRESCALER_WIDTH-1:0] PrescalerValue
);

  localparam int unsigned PW = PRESCALER_WIDTH;

  logic [1:0]    state_q, state_d;
  logic [2:0]    sel_q, sel_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          cclk_q, cclk_d;
  logic          running_q, running_d;
  logic [PW-1:0] term_cnt;
  logic          at_term;
  logic          ext_sync;

  timer_sync #(
    .STAGES(SYNC_STAGES)
  ) u_ext_sync (
    .clk  (SysClock),
    .rst_n(SysResetN),
    .d    (ExternalClock),
    .q    (ext_sync)
  );

  // Next-state and registered-output logic.
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    presc_d   = presc_q;
    cclk_d    = 1'b0;
    term_cnt  = PW'(term_count(sel_q));
    at_term   = (presc_q == term_cnt);

    case (state_q)
      ST_SWITCH: begin
        // Latch whatever is presented now; a later change re-enters SWITCH.
        sel_d   = ClockSelect;
        presc_d = '0;
        state_d = sel_is_source(ClockSelect) ? ST_RUN : ST_STOP;
      end
      ST_RUN: begin
        if (sel_q == SEL_EXT) begin
          cclk_d  = ext_sync;
          presc_d = '0;
        end else begin
          cclk_d  = at_term && !PrescalerClear;
          presc_d = at_term ? '0 : presc_q + PW'(1);
        end
      end
      ST_STOP: ;
      default: state_d = ST_STOP;
    endcase

    if (PrescalerClear) presc_d = '0;

    // Select change parks the clock low for the SWITCH cycle.
    if ((state_q != ST_SWITCH) && (ClockSelect != sel_q)) begin
      state_d = ST_SWITCH;
      presc_d = '0;
      cclk_d  = 1'b0;
    end

    running_d = (state_d == ST_RUN);
  end

  always_ff @(posedge SysClock or negedge SysResetN) begin
    if (!SysResetN) begin
      state_q   <= ST_STOP;
      sel_q     <= SEL_STOP;
      presc_q   <= '0;
      cclk_q    <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      presc_q   <= presc_d;
      cclk_q    <= cclk_d;
      running_q <= running_d;
    end
  end

  assign CounterClock   = cclk_q;
  assign Running        = running_q;
  assign PrescalerValue = presc_q;

endmodule
